// File: rtl/aes_addr_gen.sv
// aes_addr_gen: streamer-side address generator for one AES data stream.
// It accepts a start request from the AES control FSM and latches a 2-D access
// pattern. It then issues word addresses over a valid/ready handshake and pulses
// done once the last address has been accepted.
// Optional build macro: AES_ADDR_GEN_ALIGN_CHECK_EN. When it is defined, a start
// with an unaligned base or stride is rejected and err_o is raised with done_o.
module aes_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  req_start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  tot_len_i,
  input  logic [LEN_WIDTH-1:0]  d0_len_i,
  input  logic [ADDR_WIDTH-1:0] d0_stride_i,
  input  logic [ADDR_WIDTH-1:0] d1_stride_i,
  output logic                  ready_start_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  addr_valid_o,
  input  logic                  addr_ready_i,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0] d0s_q, d0s_d;
  logic [ADDR_WIDTH-1:0] d1s_q, d1s_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  inner_q, inner_d;
  logic [LEN_WIDTH-1:0]  tot_q, tot_d;
  logic [LEN_WIDTH-1:0]  d0_q, d0_d;
  logic                  valid_q, valid_d;

  logic                  misalign;
  logic                  accept;
  logic                  xfer;
  logic                  last;
  logic [LEN_WIDTH-1:0]  row_end;

`ifdef AES_ADDR_GEN_ALIGN_CHECK_EN
  assign misalign = (base_addr_i[1:0] != 2'b00) || (d0_stride_i[1:0] != 2'b00) ||
                    (d1_stride_i[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign accept  = (state_q == S_IDLE) && req_start_i;
  assign xfer    = valid_q && addr_ready_i;
  assign last    = xfer && (cnt_q == (tot_q - LEN_ONE));
  // A row length of 0 behaves like 1, so every transfer is a row step.
  assign row_end = (d0_q == '0) ? '0 : (d0_q - LEN_ONE);

  // State register: async reset, synchronous soft clear aborts any run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else if (clear) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: an empty job or a rejected start goes straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_start_i) state_d = ((tot_len_i == '0) || misalign) ? S_DONE : S_RUN;
      S_RUN:   if (last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: latch config on start, step the 2-D walk per transfer.
  always_comb begin
    addr_d     = addr_q;
    row_base_d = row_base_q;
    d0s_d      = d0s_q;
    d1s_d      = d1s_q;
    cnt_d      = cnt_q;
    inner_d    = inner_q;
    tot_d      = tot_q;
    d0_d       = d0_q;
    valid_d    = valid_q;
    if (accept) begin
      tot_d      = tot_len_i;
      d0_d       = d0_len_i;
      d0s_d      = d0_stride_i;
      d1s_d      = d1_stride_i;
      addr_d     = base_addr_i;
      row_base_d = base_addr_i;
      cnt_d      = '0;
      inner_d    = '0;
      valid_d    = (tot_len_i != '0) && !misalign;
    end else if (xfer) begin
      cnt_d   = cnt_q + LEN_ONE;
      valid_d = !last;
      if (inner_q == row_end) begin
        inner_d    = '0;
        row_base_d = row_base_q + d1s_q;
        addr_d     = row_base_q + d1s_q;
      end else begin
        inner_d = inner_q + LEN_ONE;
        addr_d  = addr_q + d0s_q;
      end
    end
  end

  // Datapath registers: cleared by reset and clear so an abort leaves no valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      row_base_q <= '0;
      d0s_q      <= '0;
      d1s_q      <= '0;
      cnt_q      <= '0;
      inner_q    <= '0;
      tot_q      <= '0;
      d0_q       <= '0;
      valid_q    <= 1'b0;
    end else if (clear) begin
      addr_q     <= '0;
      row_base_q <= '0;
      d0s_q      <= '0;
      d1s_q      <= '0;
      cnt_q      <= '0;
      inner_q    <= '0;
      tot_q      <= '0;
      d0_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      d0s_q      <= d0s_d;
      d1s_q      <= d1s_d;
      cnt_q      <= cnt_d;
      inner_q    <= inner_d;
      tot_q      <= tot_d;
      d0_q       <= d0_d;
      valid_q    <= valid_d;
    end
  end

`ifdef AES_ADDR_GEN_ALIGN_CHECK_EN
  logic err_q;

  // Error flag: remembers whether the accepted start was rejected as unaligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (clear) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misalign;
    end
  end

  assign err_o = err_q && (state_q == S_DONE);
`else
  assign err_o = 1'b0;
`endif

  assign ready_start_o = (state_q == S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign addr_o        = addr_q;
  assign addr_valid_o  = valid_q;

endmodule

// File: tb/tb_aes_addr_gen.sv
// tb_aes_addr_gen: directed bench for aes_addr_gen.
// The reference model expands each accepted job into its full list of expected
// addresses and walks that list as the consumer accepts transfers.
module tb_aes_addr_gen;

  localparam int AW = 32;
  localparam int LW = 16;

`ifdef AES_ADDR_GEN_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          req = 1'b0;
  logic [AW-1:0] base = '0;
  logic [LW-1:0] tot = '0;
  logic [LW-1:0] d0len = '0;
  logic [AW-1:0] d0s = '0;
  logic [AW-1:0] d1s = '0;
  logic          ready = 1'b0;
  logic          ready_start;
  logic [AW-1:0] addr;
  logic          valid;
  logic          done;
  logic          err;

  aes_addr_gen #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .req_start_i   (req),
    .base_addr_i   (base),
    .tot_len_i     (tot),
    .d0_len_i      (d0len),
    .d0_stride_i   (d0s),
    .d1_stride_i   (d1s),
    .ready_start_o (ready_start),
    .addr_o        (addr),
    .addr_valid_o  (valid),
    .addr_ready_i  (ready),
    .done_o        (done),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  bit            chk_en = 1'b0;
  int            done_cnt = 0;
  logic [AW-1:0] log_q[$];
  logic [AW-1:0] exp_a[16];

  // Reference model: 0 idle, 1 issuing addresses, 2 done pulse.
  int            m_phase = 0;
  logic [AW-1:0] m_q[$];
  bit            m_err = 1'b0;

  task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  initial begin
    bit mis;
    int eff;
    forever begin
      @(posedge clk or posedge reset);
      if (reset || clear) begin
        m_phase = 0;
        m_q.delete();
        m_err = 1'b0;
      end else begin
        case (m_phase)
          0: if (req) begin
            mis = ALIGN_EN && ((base[1:0] != 2'b00) || (d0s[1:0] != 2'b00) || (d1s[1:0] != 2'b00));
            m_err = mis;
            m_q.delete();
            if ((tot == '0) || mis) begin
              m_phase = 2;
            end else begin
              eff = (d0len == '0) ? 1 : int'(d0len);
              for (int i = 0; i < int'(tot); i++)
                m_q.push_back(base + AW'(i / eff) * d1s + AW'(i % eff) * d0s);
              m_phase = 1;
            end
          end
          1: if (ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_phase = 2;
          end
          default: begin
            m_phase = 0;
            m_err = 1'b0;
          end
        endcase
      end
    end
  end

  // Transfer log and done-pulse counter, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (valid && ready) log_q.push_back(addr);
        if (done) done_cnt++;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("ready_start_o", AW'(ready_start), AW'(m_phase == 0));
        chk("addr_valid_o", AW'(valid), AW'(m_phase == 1));
        if (m_phase == 1 && m_q.size() > 0) chk("addr_o", addr, m_q[0]);
        chk("done_o", AW'(done), AW'(m_phase == 2));
        chk("err_o", AW'(err), AW'((m_phase == 2) && m_err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [AW-1:0] b, input logic [LW-1:0] t,
                           input logic [LW-1:0] dl, input logic [AW-1:0] s0,
                           input logic [AW-1:0] s1);
    log_q.delete();
    base  = b;
    tot   = t;
    d0len = dl;
    d0s   = s0;
    d1s   = s1;
    req   = 1'b1;
    tick();
    req   = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      seen = (done === 1'b1);
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s_timeout: done_o not seen, expected within %0d cycles", nm, budget);
    end
    tick();
  endtask

  task automatic check_log(input string nm, input int n);
    chk({nm, "_count"}, AW'(log_q.size()), AW'(n));
    for (int i = 0; i < n; i++)
      if (i < log_q.size()) chk($sformatf("%s_addr%0d", nm, i), log_q[i], exp_a[i]);
  endtask

  initial begin
    int dc;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_start", AW'(ready_start), AW'(1));
    chk("rst_valid", AW'(valid), AW'(0));
    chk("rst_addr", addr, AW'(0));
    chk("rst_done", AW'(done), AW'(0));
    chk("rst_err", AW'(err), AW'(0));
    reset = 1'b0;
    chk_en = 1'b1;
    tick();

    // Linear run.
    ready = 1'b1;
    start_job(32'h1000, 16'd4, 16'd4, 32'h4, 32'h0);
    chk("lin_first_valid", AW'(valid), AW'(1));
    chk("lin_first_addr", addr, 32'h1000);
    wait_done("lin", 20);
    chk("lin_ready_after_done", AW'(ready_start), AW'(1));
    exp_a[0] = 32'h1000; exp_a[1] = 32'h1004; exp_a[2] = 32'h1008; exp_a[3] = 32'h100C;
    check_log("lin", 4);

    // 2-D run.
    start_job(32'h2000, 16'd6, 16'd3, 32'h4, 32'h40);
    wait_done("twod", 20);
    exp_a[0] = 32'h2000; exp_a[1] = 32'h2004; exp_a[2] = 32'h2008;
    exp_a[3] = 32'h2040; exp_a[4] = 32'h2044; exp_a[5] = 32'h2048;
    check_log("twod", 6);

    // Backpressure for 3 cycles, with a stray start request while running.
    start_job(32'h3000, 16'd6, 16'd6, 32'h4, 32'h0);
    tick();
    tick();
    ready = 1'b0;
    base  = 32'h9000;
    req   = 1'b1;
    tick();
    req   = 1'b0;
    chk("bp_hold_addr", addr, 32'h3008);
    tick();
    tick();
    ready = 1'b1;
    wait_done("bp", 20);
    for (int i = 0; i < 6; i++) exp_a[i] = 32'h3000 + AW'(4 * i);
    check_log("bp", 6);

    // Empty job.
    start_job(32'h7000, 16'd0, 16'd4, 32'h4, 32'h0);
    chk("empty_done_now", AW'(done), AW'(1));
    chk("empty_no_valid", AW'(valid), AW'(0));
    wait_done("empty", 5);
    check_log("empty", 0);

    // Row length 0 behaves like 1.
    start_job(32'h0, 16'd3, 16'd0, 32'h4, 32'h10);
    wait_done("d0zero", 20);
    exp_a[0] = 32'h0; exp_a[1] = 32'h10; exp_a[2] = 32'h20;
    check_log("d0zero", 3);

    // Address wrap-around.
    start_job(32'hFFFF_FFF8, 16'd4, 16'd4, 32'h4, 32'h0);
    wait_done("wrap", 20);
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0; exp_a[3] = 32'h4;
    check_log("wrap", 4);

`ifdef AES_ADDR_GEN_ALIGN_CHECK_EN
    start_job(32'h1002, 16'd4, 16'd4, 32'h4, 32'h0);
    chk("align_done", AW'(done), AW'(1));
    chk("align_err", AW'(err), AW'(1));
    wait_done("align_bad", 5);
    check_log("align_bad", 0);
    start_job(32'h1000, 16'd2, 16'd2, 32'h4, 32'h0);
    wait_done("align_ok", 20);
    exp_a[0] = 32'h1000; exp_a[1] = 32'h1004;
    check_log("align_ok", 2);
`else
    start_job(32'h1002, 16'd2, 16'd2, 32'h4, 32'h0);
    wait_done("unaligned", 20);
    exp_a[0] = 32'h1002; exp_a[1] = 32'h1006;
    check_log("unaligned", 2);
`endif

    // Abort with asynchronous reset after the 2nd transfer.
    dc = done_cnt;
    start_job(32'h4000, 16'd8, 16'd8, 32'h4, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    ready = 1'b0;
    #1;
    chk("rst_abort_valid", AW'(valid), AW'(0));
    chk("rst_abort_addr", addr, AW'(0));
    tick();
    reset = 1'b0;
    ready = 1'b1;
    repeat (3) tick();
    chk("rst_abort_no_done", AW'(done_cnt), AW'(dc));
    start_job(32'h4000, 16'd2, 16'd2, 32'h4, 32'h0);
    wait_done("rst_restart", 20);
    exp_a[0] = 32'h4000; exp_a[1] = 32'h4004;
    check_log("rst_restart", 2);

    // Abort with synchronous clear after the 2nd transfer.
    dc = done_cnt;
    start_job(32'h4000, 16'd8, 16'd8, 32'h4, 32'h0);
    tick();
    tick();
    clear = 1'b1;
    ready = 1'b0;
    chk("clr_pending_valid", AW'(valid), AW'(1));
    tick();
    clear = 1'b0;
    chk("clr_abort_valid", AW'(valid), AW'(0));
    ready = 1'b1;
    repeat (3) tick();
    chk("clr_abort_no_done", AW'(done_cnt), AW'(dc));
    start_job(32'h4000, 16'd2, 16'd2, 32'h4, 32'h0);
    wait_done("clr_restart", 20);
    check_log("clr_restart", 2);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
